// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the decimating FIR filter:
//   - fir_state_e : control FSM states (FILL, MAC, WRITE)
//   - dequantize  : signed division by 2^qbits, truncating toward zero
//   - saturate    : clamp a wide signed value to a data_width-bit signed range
// The helpers work on a fixed wide signed type; callers sign-extend into it
// and truncate the result back to their own width.
// -----------------------------------------------------------------------------
package fir_pkg;

    // Working width of the arithmetic helpers; covers DATA_WIDTH+COEFF_WIDTH
    // products and accumulators for all supported configurations.
    localparam int WIDE_W = 128;

    localparam logic signed [WIDE_W-1:0] WIDE_ONE = 128'sd1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2
    } fir_state_e;

    // Truncating division: an arithmetic shift rounds toward -inf, so negative
    // values get a bias of (2^qbits - 1) first to round toward zero instead.
    function automatic logic signed [WIDE_W-1:0] dequantize(
        input logic signed [WIDE_W-1:0] product,
        input int unsigned              qbits
    );
        logic signed [WIDE_W-1:0] bias;
        bias = (WIDE_ONE <<< qbits) - WIDE_ONE;
        if (product[WIDE_W-1]) begin
            dequantize = (product + bias) >>> qbits;
        end else begin
            dequantize = product >>> qbits;
        end
    endfunction

    // Clamp to [-2^(data_width-1), 2^(data_width-1)-1].
    function automatic logic signed [WIDE_W-1:0] saturate(
        input logic signed [WIDE_W-1:0] acc,
        input int unsigned              data_width
    );
        logic signed [WIDE_W-1:0] max_v;
        logic signed [WIDE_W-1:0] min_v;
        max_v = (WIDE_ONE <<< (data_width - 32'd1)) - WIDE_ONE;
        min_v = -(WIDE_ONE <<< (data_width - 32'd1));
        if (acc > max_v) begin
            saturate = max_v;
        end else if (acc < min_v) begin
            saturate = min_v;
        end else begin
            saturate = acc;
        end
    endfunction

endpackage

// File: rtl/fir_mac.sv
// -----------------------------------------------------------------------------
// fir_mac
// Multiply-dequantize-accumulate datapath of the FIR filter.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   clr          : clear accumulator at the next edge (has priority over en)
//   en           : add one dequantised term at the next edge
//   sample       : signed history sample x[k]
//   coeff        : signed coefficient paired with x[k]
//   acc          : registered signed accumulator
// -----------------------------------------------------------------------------
module fir_mac
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int COEFF_WIDTH = 32,
    parameter int QUANT_BITS  = 10,
    parameter int ACC_WIDTH   = 38
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clr,
    input  logic                          en,
    input  logic signed [DATA_WIDTH-1:0]  sample,
    input  logic signed [COEFF_WIDTH-1:0] coeff,
    output logic signed [ACC_WIDTH-1:0]   acc
);

    localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;

    logic signed [PROD_W-1:0]    product_s;
    logic signed [ACC_WIDTH-1:0] term_s;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic signed [ACC_WIDTH-1:0] acc_q;

    // Full-width signed product, dequantised and sign-extended to the accumulator.
    always_comb begin
        product_s = PROD_W'(sample) * PROD_W'(coeff);
        term_s    = ACC_WIDTH'(dequantize(WIDE_W'(product_s), QUANT_BITS));
    end

    // Accumulator next value: clear, accumulate or hold.
    always_comb begin
        if (clr) begin
            acc_d = {ACC_WIDTH{1'b0}};
        end else if (en) begin
            acc_d = acc_q + term_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q <= {ACC_WIDTH{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/fir_decim.sv
// -----------------------------------------------------------------------------
// fir_decim
// Parametrised decimating FIR filter between an input and an output FIFO.
// Reads DECIMATION samples into a TAPS-entry ring buffer, then spends TAPS
// cycles accumulating sum(dq(c[TAPS-1-k] * x[k])), then writes one saturated
// result to the output FIFO.
// Ports:
//   clock, reset         : clock and asynchronous active-high reset
//   x_in, x_empty        : input FIFO data / empty flag
//   x_rd_en              : input FIFO read (combinational)
//   y_out, y_wr_en       : output sample / write strobe (both registered)
//   y_out_full           : output FIFO full
//   coef_wr_en, coef_addr, coef_data : runtime coefficient write port
//   coef_ready           : coefficient write will be accepted (combinational)
// -----------------------------------------------------------------------------
module fir_decim
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int COEFF_WIDTH = 32,
    parameter int TAPS        = 32,
    parameter int DECIMATION  = 8,
    parameter int QUANT_BITS  = 10,
    parameter int ACC_WIDTH   = DATA_WIDTH + $clog2(TAPS) + 1,
    parameter logic [0:TAPS-1][COEFF_WIDTH-1:0] COEFF_INIT = {(TAPS*COEFF_WIDTH){1'b0}}
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   x_in,
    input  logic                    x_empty,
    output logic                    x_rd_en,
    output logic [DATA_WIDTH-1:0]   y_out,
    input  logic                    y_out_full,
    output logic                    y_wr_en,
    input  logic                    coef_wr_en,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [COEFF_WIDTH-1:0]  coef_data,
    output logic                    coef_ready
);

    localparam int PTR_W = $clog2(TAPS);
    localparam int PH_W  = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;

    localparam logic [PTR_W-1:0] LAST_TAP   = PTR_W'(TAPS - 1);
    localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(DECIMATION - 1);
    localparam logic [PTR_W:0]   TAPS_EXT   = (PTR_W + 1)'(TAPS);

    fir_state_e              state_q, state_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        tap_q, tap_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [DATA_WIDTH-1:0]   y_out_q, y_out_d;
    logic                    y_wr_en_q, y_wr_en_d;
    logic [DATA_WIDTH-1:0]   hist_q [TAPS];
    logic [DATA_WIDTH-1:0]   hist_d [TAPS];
    logic [COEFF_WIDTH-1:0]  coef_q [TAPS];
    logic [COEFF_WIDTH-1:0]  coef_d [TAPS];

    logic                    rd_en_s;
    logic                    coef_ok_s;
    logic                    mac_clr_s;
    logic                    mac_en_s;
    logic [PTR_W-1:0]        coef_idx_s;
    logic signed [ACC_WIDTH-1:0] acc_s;

    // FIFO read and coefficient-port ready decode; both held low during reset.
    always_comb begin
        if (reset) begin
            rd_en_s   = 1'b0;
            coef_ok_s = 1'b0;
        end else begin
            rd_en_s   = (state_q == FILL) && !x_empty;
            coef_ok_s = (state_q == FILL);
        end
    end

    assign x_rd_en    = rd_en_s;
    assign coef_ready = coef_ok_s;

    // Tap k pairs the k-th newest sample with c[TAPS-1-k].
    assign coef_idx_s = LAST_TAP - tap_q;

    // Control FSM next state, pointers, history writes and output register.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        tap_d     = tap_q;
        phase_d   = phase_q;
        hist_d    = hist_q;
        y_out_d   = y_out_q;
        y_wr_en_d = 1'b0;
        mac_clr_s = 1'b0;
        mac_en_s  = 1'b0;
        case (state_q)
            FILL: begin
                if (rd_en_s) begin
                    hist_d[wr_ptr_q] = x_in;
                    wr_ptr_d = (wr_ptr_q == LAST_TAP) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
                    if (phase_q == LAST_PHASE) begin
                        // The slot written now is the newest sample x[0].
                        phase_d   = {PH_W{1'b0}};
                        state_d   = MAC;
                        tap_d     = {PTR_W{1'b0}};
                        rd_ptr_d  = wr_ptr_q;
                        mac_clr_s = 1'b1;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end else begin
                    phase_d = phase_q;
                end
            end
            MAC: begin
                mac_en_s = 1'b1;
                if (tap_q == LAST_TAP) begin
                    state_d = WRITE;
                    tap_d   = {PTR_W{1'b0}};
                end else begin
                    tap_d    = tap_q + PTR_W'(1);
                    // Walk backwards through the ring toward older samples.
                    rd_ptr_d = (rd_ptr_q == {PTR_W{1'b0}}) ? LAST_TAP : rd_ptr_q - PTR_W'(1);
                end
            end
            WRITE: begin
                if (!y_out_full) begin
                    y_out_d   = DATA_WIDTH'(saturate(WIDE_W'(acc_s), DATA_WIDTH));
                    y_wr_en_d = 1'b1;
                    state_d   = FILL;
                end else begin
                    state_d = WRITE;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Coefficient update: only in FILL, only for in-range addresses.
    always_comb begin
        coef_d = coef_q;
        if (coef_wr_en && coef_ok_s && ({1'b0, coef_addr} < TAPS_EXT)) begin
            coef_d[coef_addr] = coef_data;
        end else begin
            coef_d = coef_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= FILL;
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            tap_q     <= {PTR_W{1'b0}};
            phase_q   <= {PH_W{1'b0}};
            y_out_q   <= {DATA_WIDTH{1'b0}};
            y_wr_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            tap_q     <= tap_d;
            phase_q   <= phase_d;
            y_out_q   <= y_out_d;
            y_wr_en_q <= y_wr_en_d;
        end
    end

    // Sample history and coefficient storage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                hist_q[i] <= {DATA_WIDTH{1'b0}};
                coef_q[i] <= COEFF_INIT[i];
            end
        end else begin
            hist_q <= hist_d;
            coef_q <= coef_d;
        end
    end

    fir_mac #(
        .DATA_WIDTH  (DATA_WIDTH),
        .COEFF_WIDTH (COEFF_WIDTH),
        .QUANT_BITS  (QUANT_BITS),
        .ACC_WIDTH   (ACC_WIDTH)
    ) u_mac (
        .clock  (clock),
        .reset  (reset),
        .clr    (mac_clr_s),
        .en     (mac_en_s),
        .sample ($signed(hist_q[rd_ptr_q])),
        .coeff  ($signed(coef_q[coef_idx_s])),
        .acc    (acc_s)
    );

    assign y_out   = y_out_q;
    assign y_wr_en = y_wr_en_q;

endmodule
